// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, fetch FSM encoding and PC helpers
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - single-entry {inst, pc4} holding register for the fetch HOLD state
module fetch_skid
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Load wins over clear so a capture is never lost to a stale clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst  <= NOP_INST;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - MIPS IF stage sequencer; FETCH_PERF_EN adds fetch/stall/bubble counters
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_s1_s2,
    input  logic        i_pcsrc,
    input  logic [31:0] i_baddr_s2,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc4_s2,
    output logic [31:0] o_inst_s2,
    output logic        o_valid_s2,
    output logic        o_branch_flush,
    output logic        o_imem_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_stall,
    output logic [31:0] o_perf_bubble
`endif
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    fetch_state_t  r_state;
    logic          r_req;
    logic [31:0]   r_pc;
    logic [31:0]   r_tgt;
    logic [31:0]   r_inst;
    logic [31:0]   r_pc4;
    logic          r_valid;
    logic          r_discard;
    logic          r_err;
    logic [WW-1:0] r_wait;

    logic          w_redirect;
    logic          w_ack;
    logic [31:0]   w_target;
    logic [31:0]   w_pc_next;
    logic          w_skid_load;
    logic          w_skid_clr;
    logic [31:0]   w_skid_inst;
    logic [31:0]   w_skid_pc4;
    logic          w_skid_valid;

    assign w_redirect  = i_pcsrc & ~i_stall_s1_s2;
    assign w_ack       = r_req & i_imem_ack;
    assign w_target    = word_align(i_baddr_s2);
    assign w_pc_next   = r_pc + PC_STEP;
    assign w_skid_load = (r_state == FS_REQ) & w_ack & i_stall_s1_s2 & ~r_discard;
    assign w_skid_clr  = (r_state == FS_HOLD) & ~i_stall_s1_s2;

    fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_inst  (i_imem_rdata),
        .i_pc4   (w_pc_next),
        .o_inst  (w_skid_inst),
        .o_pc4   (w_skid_pc4),
        .o_valid (w_skid_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= FS_IDLE;
            r_req     <= 1'b0;
            r_pc      <= word_align(RESET_PC);
            r_tgt     <= '0;
            r_inst    <= NOP_INST;
            r_pc4     <= '0;
            r_valid   <= 1'b0;
            r_discard <= 1'b0;
            r_wait    <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_state <= FS_REQ;
                    r_req   <= 1'b1;
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                FS_REQ: begin
                    if (w_ack) begin
                        r_wait <= '0;
                    end else if (r_wait == WAIT_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end

                    // The address must not move while req is high, so an
                    // unacked redirect parks its target until the ack.
                    if (w_redirect) begin
                        r_valid <= 1'b0;
                        r_inst  <= NOP_INST;
                        if (w_ack) begin
                            r_pc      <= w_target;
                            r_discard <= 1'b0;
                        end else begin
                            r_tgt     <= w_target;
                            r_discard <= 1'b1;
                        end
                    end else if (w_ack) begin
                        if (r_discard) begin
                            r_pc      <= r_tgt;
                            r_discard <= 1'b0;
                            if (!i_stall_s1_s2) begin
                                r_valid <= 1'b0;
                                r_inst  <= NOP_INST;
                            end
                        end else if (i_stall_s1_s2) begin
                            r_pc    <= w_pc_next;
                            r_state <= FS_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_inst  <= i_imem_rdata;
                            r_pc4   <= w_pc_next;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_next;
                        end
                    end else if (!i_stall_s1_s2) begin
                        r_valid <= 1'b0;
                        r_inst  <= NOP_INST;
                    end
                end
                FS_HOLD: begin
                    if (!i_stall_s1_s2) begin
                        r_state <= FS_REQ;
                        r_req   <= 1'b1;
                        if (i_pcsrc) begin
                            r_pc    <= w_target;
                            r_valid <= 1'b0;
                            r_inst  <= NOP_INST;
                        end else begin
                            r_inst  <= w_skid_inst;
                            r_pc4   <= w_skid_pc4;
                            r_valid <= w_skid_valid;
                        end
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req     = r_req;
    assign o_imem_addr    = r_pc;
    assign o_pc4_s2       = r_pc4;
    assign o_inst_s2      = r_inst;
    assign o_valid_s2     = r_valid;
    assign o_branch_flush = w_redirect;
    assign o_imem_err     = r_err;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic        w_deliver;
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_bubble;

    assign w_deliver = ~i_stall_s1_s2 & ~i_pcsrc &
                       (((r_state == FS_REQ) & w_ack & ~r_discard) | (r_state == FS_HOLD));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_fetch  <= '0;
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_deliver && (r_perf_fetch != CNT_MAX)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (i_stall_s1_s2 && (r_perf_stall != CNT_MAX)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (!r_valid && (r_perf_bubble != CNT_MAX)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign o_perf_fetch  = r_perf_fetch;
    assign o_perf_stall  = r_perf_stall;
    assign o_perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a program-order model
module tb_fetch_ctrl;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc4_s2;
    logic [31:0] inst_s2;
    logic        valid_s2;
    logic        branch_flush;
    logic        imem_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_bubble;
`endif

    int checks = 0;
    int errors = 0;
    logic ack_allow;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall_s1_s2  (stall),
        .i_pcsrc        (pcsrc),
        .i_baddr_s2     (baddr),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_ack     (ack),
        .i_imem_rdata   (rdata),
        .o_pc4_s2       (pc4_s2),
        .o_inst_s2      (inst_s2),
        .o_valid_s2     (valid_s2),
        .o_branch_flush (branch_flush),
        .o_imem_err     (imem_err)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_fetch   (perf_fetch),
        .o_perf_stall   (perf_stall),
        .o_perf_bubble  (perf_bubble)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers this cycle's request (if allowed), then sample at the falling edge.
    task automatic cyc();
        ack   = imem_req & ack_allow;
        rdata = mem_word(imem_addr);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_next;
        logic [31:0] cur_addr, cur_inst, cur_pc4;
        logic        cur_req, cur_valid;
        logic        s, p, a;
        logic [31:0] b;
        logic        exp_err;
        int          wcnt;
        int          deliveries;

        rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; baddr = '0;
        ack = 1'b0; rdata = '0; ack_allow = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid_s2), 32'd0);
        chk("rst_inst",  inst_s2, 32'd0);
        chk("rst_pc4",   pc4_s2, 32'd0);
        chk("rst_err",   32'(imem_err), 32'd0);

        // zero-wait stream from RESET_PC
        rst = 1'b0; ack_allow = 1'b1;
        cyc();
        chk("first_req",   32'(imem_req), 32'd1);
        chk("first_addr",  imem_addr, 32'h0);
        chk("first_valid", 32'(valid_s2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("zw_valid", 32'(valid_s2), 32'd1);
            chk("zw_pc4",   pc4_s2, 32'(4 * (i + 1)));
            chk("zw_inst",  inst_s2, mem_word(32'(4 * i)));
            chk("zw_addr",  imem_addr, 32'(4 * (i + 1)));
        end

        // ack three cycles late at 0x10
        ack_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("late_addr",  imem_addr, 32'h10);
            chk("late_req",   32'(imem_req), 32'd1);
            chk("late_valid", 32'(valid_s2), 32'd0);
            chk("late_nop",   inst_s2, 32'h0);
        end
        ack_allow = 1'b1;
        cyc();
        chk("late_dvalid", 32'(valid_s2), 32'd1);
        chk("late_pc4",    pc4_s2, 32'h14);
        chk("late_inst",   inst_s2, mem_word(32'h10));

        // stall on the ack cycle for two cycles
        stall = 1'b1;
        cyc();
        chk("hold1_req",  32'(imem_req), 32'd0);
        chk("hold1_pc4",  pc4_s2, 32'h14);
        chk("hold1_inst", inst_s2, mem_word(32'h10));
        cyc();
        chk("hold2_req",  32'(imem_req), 32'd0);
        chk("hold2_inst", inst_s2, mem_word(32'h10));
        stall = 1'b0;
        cyc();
        chk("skid_valid", 32'(valid_s2), 32'd1);
        chk("skid_pc4",   pc4_s2, 32'h18);
        chk("skid_inst",  inst_s2, mem_word(32'h14));
        chk("skid_addr",  imem_addr, 32'h18);
        cyc();
        chk("after_skid_pc4", pc4_s2, 32'h1C);
        cyc();
        chk("at_0x20_addr", imem_addr, 32'h20);

        // redirect to 0x40 while 0x20 is pending, ack two cycles later
        ack_allow = 1'b0; pcsrc = 1'b1; baddr = 32'h40;
        #1 chk("redir_flush", 32'(branch_flush), 32'd1);
        cyc();
        chk("redir_valid", 32'(valid_s2), 32'd0);
        chk("redir_addr_hold", imem_addr, 32'h20);
        pcsrc = 1'b0;
        #1 chk("redir_flush_off", 32'(branch_flush), 32'd0);
        cyc();
        chk("redir_addr_hold2", imem_addr, 32'h20);
        ack_allow = 1'b1;
        cyc();
        chk("redir_drop_valid", 32'(valid_s2), 32'd0);
        chk("redir_tgt_addr",   imem_addr, 32'h40);
        cyc();
        chk("redir_pc4",  pc4_s2, 32'h44);
        chk("redir_inst", inst_s2, mem_word(32'h40));

        // zero-wait redirect latency, unaligned target
        pcsrc = 1'b1; baddr = 32'h83;
        cyc();
        chk("lat_valid", 32'(valid_s2), 32'd0);
        chk("lat_addr",  imem_addr, 32'h80);
        pcsrc = 1'b0;
        cyc();
        chk("lat_dvalid", 32'(valid_s2), 32'd1);
        chk("lat_pc4",    pc4_s2, 32'h84);

        // redirect during stall is ignored
        stall = 1'b1; pcsrc = 1'b1; baddr = 32'h200; ack_allow = 1'b0;
        #1 chk("stall_noflush", 32'(branch_flush), 32'd0);
        cyc();
        chk("stall_addr", imem_addr, 32'h84);
        chk("stall_pc4",  pc4_s2, 32'h84);
        stall = 1'b0; pcsrc = 1'b0; ack_allow = 1'b1;
        cyc();
        chk("stall_next_pc4", pc4_s2, 32'h88);

        // PC wrap
        pcsrc = 1'b1; baddr = 32'hFFFF_FFFC;
        cyc();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        pcsrc = 1'b0;
        cyc();
        chk("wrap_pc4",  pc4_s2, 32'h0);
        chk("wrap_inst", inst_s2, mem_word(32'hFFFF_FFFC));
        chk("wrap_addr0", imem_addr, 32'h0);

        // timeout, then reset mid-wait
        ack_allow = 1'b0;
        for (int k = 1; k <= MAX_WAIT + 3; k++) begin
            cyc();
            chk("to_err",  32'(imem_err), 32'(k >= MAX_WAIT));
            chk("to_req",  32'(imem_req), 32'd1);
            chk("to_addr", imem_addr, 32'h0);
        end
        rst = 1'b1;
        cyc();
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_err", 32'(imem_err), 32'd0);
        rst = 1'b0; ack_allow = 1'b1;
        cyc();
        chk("mid_rst_addr", imem_addr, 32'h0);
        cyc();
        chk("mid_rst_pc4", pc4_s2, 32'h4);

        // randomized: delivered stream must follow program order with redirects
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_next = 32'h0; exp_err = 1'b0; wcnt = 0; deliveries = 0;
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 7) == 0);
            b = $urandom;
            a = imem_req && ((wcnt >= 8) || ($urandom_range(0, 2) != 0));
            stall = s; pcsrc = p; baddr = b; ack = a;
            rdata = mem_word(imem_addr);
            #1 chk("rand_flush", 32'(branch_flush), 32'(p & ~s));
            cur_req = imem_req; cur_addr = imem_addr;
            cur_valid = valid_s2; cur_inst = inst_s2; cur_pc4 = pc4_s2;
            if (cur_req && !a) wcnt++;
            else wcnt = 0;
            if (wcnt >= MAX_WAIT) exp_err = 1'b1;
            @(negedge clk);
            chk("rand_err", 32'(imem_err), 32'(exp_err));
            if (cur_req && !a) begin
                chk("rand_req_hold",  32'(imem_req), 32'd1);
                chk("rand_addr_hold", imem_addr, cur_addr);
            end
            if (imem_req) chk("rand_align", 32'(imem_addr[1:0]), 32'd0);
            if (s) begin
                chk("rand_stall_valid", 32'(valid_s2), 32'(cur_valid));
                chk("rand_stall_inst",  inst_s2, cur_inst);
                chk("rand_stall_pc4",   pc4_s2, cur_pc4);
            end else if (p) begin
                chk("rand_flush_valid", 32'(valid_s2), 32'd0);
            end else if (valid_s2) begin
                chk("rand_pc4",  pc4_s2, exp_next + 32'd4);
                chk("rand_inst", inst_s2, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                deliveries++;
            end
            if (!valid_s2) chk("rand_nop", inst_s2, 32'h0);
            if (p && !s) exp_next = {b[31:2], 2'b00};
        end
        stall = 1'b0; pcsrc = 1'b0;
        chk("rand_progress", 32'(deliveries > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
